rst_status_table: RTL and testbench
===================================

Name: rst_status_table

Overview:
- Parametrised register status table (RST) for the dispatch stage.
- Tracks, per architectural register, whether a result is pending (busy), which FU tag will produce it, and whether the producer is speculative.
- Dispatch claims destinations, writeback releases them, and branch resolution commits or squashes speculative claims.
- Replaces the fixed 2-bit-tag scalar/matrix RST structs. One instance serves scalar (NUM_REGS=32) and one serves matrix (NUM_REGS=16).

Parameters:
- NUM_REGS, 32, number of tracked registers.
- TAG_W, 2, FU tag width.
- NUM_WB, 2, writeback release ports.
- NUM_RD, 3, source lookup ports.
- ZERO_REG, 1, if 1, register 0 is hardwired never-busy.
- IDX_W, $clog2(NUM_REGS), register index width (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- di_en  in  1  dispatch claims di_rd this cycle.
- di_rd  in  IDX_W  destination register.
- di_tag  in  TAG_W  producing FU tag.
- di_spec  in  1  instruction issued under an unresolved branch.
- di_waw  out  1  combinational; di_rd is busy and not being released this cycle; dispatch must stall.
- rd_idx  in  NUM_RD*IDX_W  source register indices, packed.
- rd_busy  out  NUM_RD  busy bit per lookup port.
- rd_tag  out  NUM_RD*TAG_W  producer tag per lookup port.
- rd_spec  out  NUM_RD  spec bit per lookup port.
- wb_en  in  NUM_WB  release request per port.
- wb_rd  in  NUM_WB*IDX_W  released register.
- wb_tag  in  NUM_WB*TAG_W  tag of the completing FU.
- br_resolve  in  1  pulse: oldest branch resolved.
- br_mispredict  in  1  qualifies br_resolve; 1 means squash.
- busy_cnt  out  $clog2(NUM_REGS+1)  registered count of busy entries.
- err_waw  out  1  registered one-cycle pulse; dispatch was attempted while di_waw was high.

Behaviour:
- State per entry: busy, tag[TAG_W], spec.
- Reset (async, nRST=0): all entries busy=0, tag=0, spec=0; busy_cnt=0; err_waw=0. Reset mid-operation discards every claim immediately, with no clock needed.
- Lookups (rd_*) are purely combinational reads of the registered state. There is no writeback bypass: a release in cycle N is visible in cycle N+1.
- Release: for each port p with wb_en[p], clear busy and spec of wb_rd[p] only if the entry is busy and its tag == wb_tag[p]. On a tag mismatch (stale writeback), do nothing.
  - Two ports may target the same register; either match clears it.
  - A release takes effect at the next edge.
- di_waw = entry[di_rd].busy AND NOT (any port p with wb_en[p], wb_rd[p]==di_rd, tag match).
- Claim: if di_en and not di_waw, at the edge write busy=1, tag=di_tag, spec=di_spec.
  - A claim and a release of the same register in the same cycle: the claim wins and the entry holds the new owner.
  - If di_en and di_waw, the claim is dropped and err_waw=1 for exactly the next cycle.
- Branch, when br_resolve=1:
  - br_mispredict=0: clear spec on all entries. A same-cycle claim is also written with spec=0 (single speculation level).
  - br_mispredict=1: every entry with spec=1 gets busy=0, spec=0, tag=0. A same-cycle claim with di_spec=1 is dropped and does not raise err_waw. A same-cycle claim with di_spec=0 proceeds.
  - A squash and a release of the same entry in the same cycle resolve to busy=0.
  - br_mispredict without br_resolve is ignored.
- ZERO_REG=1: claims of register 0 are ignored; lookups of register 0 return busy=0, tag=0, spec=0; di_waw=0 for rd 0.
- Out-of-range indices (>= NUM_REGS, when NUM_REGS is not a power of 2): claims ignored, lookups return 0.
- Update priority per entry, highest first: reset > squash > claim > release > spec-commit.
- busy_cnt is the popcount of the post-update busy vector, registered; it is valid one cycle after the edge that changed state.

Test Plan:
- Reset then lookup: rd_idx={5,0,31} -> rd_busy=000, busy_cnt=0, err_waw=0.
- Claim rd=5, tag=2, spec=0; next cycle lookup 5 -> busy=1, tag=2, busy_cnt=1. Release with wb_rd=5, wb_tag=1 -> still busy. Release with wb_tag=2 -> busy=0 next cycle, busy_cnt=0.
- rd=7 busy with tag 1:
  - Claim rd=7 tag 3 with no release -> di_waw=1, entry unchanged, err_waw pulses one cycle.
  - Same claim with wb_en[1]=1, wb_rd=7, wb_tag=1 in the same cycle -> di_waw=0, entry becomes tag 3, busy=1.
- Claim rd=3 (spec=1), rd=4 (spec=0), rd=9 (spec=1); then br_resolve=1 with br_mispredict=1 plus a same-cycle claim of rd=10 with di_spec=1 -> next cycle busy only at reg 4, busy_cnt=1, err_waw=0.
- Claim rd=3 (spec=1); br_resolve=1, br_mispredict=0 with a same-cycle claim of rd=6 (spec=1) -> rd_spec=0 for both 3 and 6, both busy.
- Claim rd=0 with ZERO_REG=1 -> busy_cnt stays 0. Assert nRST=0 asynchronously mid-cycle with 4 entries busy -> all rd_busy=0 and busy_cnt=0 without waiting for a clock edge.

Source files
------------

// File: rtl/rst_status_table.sv
// Register status table: per-register busy/tag/spec scoreboard for dispatch.
// Dispatch claims destinations, writeback releases them, branch resolution commits or squashes.
module rst_status_table #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 2,
    parameter int NUM_WB   = 2,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              di_en,
    input  logic [IDX_W-1:0]                  di_rd,
    input  logic [TAG_W-1:0]                  di_tag,
    input  logic                              di_spec,
    output logic                              di_waw,
    input  logic [NUM_RD*IDX_W-1:0]           rd_idx,
    output logic [NUM_RD-1:0]                 rd_busy,
    output logic [NUM_RD*TAG_W-1:0]           rd_tag,
    output logic [NUM_RD-1:0]                 rd_spec,
    input  logic [NUM_WB-1:0]                 wb_en,
    input  logic [NUM_WB*IDX_W-1:0]           wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]           wb_tag,
    input  logic                              br_resolve,
    input  logic                              br_mispredict,
    output logic [$clog2(NUM_REGS+1)-1:0]     busy_cnt,
    output logic                              err_waw
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] busy_reg, busy_next;
    logic [NUM_REGS-1:0] spec_reg, spec_next;
    logic [TAG_W-1:0]    tag_reg  [NUM_REGS];
    logic [TAG_W-1:0]    tag_next [NUM_REGS];
    logic [NUM_REGS-1:0] rel_hit;
    logic [NUM_REGS-1:0] claim_sel;
    logic [CNT_W-1:0]    cnt_next;

    logic squash, commit, claim_ok, err_next;
    logic di_busy, di_hit;

    assign squash = br_resolve & br_mispredict;
    assign commit = br_resolve & ~br_mispredict;

    // Out-of-range di_rd never matches an entry, so it reads as not busy.
    always_comb begin
        di_busy = 1'b0;
        di_hit  = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (di_rd == IDX_W'(r)) begin
                di_busy = busy_reg[r];
                di_hit  = rel_hit[r];
            end
        end
    end

    assign di_waw   = di_busy & ~di_hit;
    // A speculative claim racing a squash is silently dropped, never flagged.
    assign claim_ok = di_en & ~di_waw & ~(squash & di_spec);
    assign err_next = di_en &  di_waw & ~(squash & di_spec);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            logic             hit;
            logic             b_n;
            logic             s_n;
            logic [TAG_W-1:0] t_n;

            always_comb begin
                hit = 1'b0;
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_en[p] && wb_rd[p*IDX_W +: IDX_W] == IDX_W'(gi) &&
                        wb_tag[p*TAG_W +: TAG_W] == tag_reg[gi])
                        hit = 1'b1;
                end
            end

            assign rel_hit[gi]   = hit & busy_reg[gi];
            assign claim_sel[gi] = claim_ok && (di_rd == IDX_W'(gi)) && !(ZERO_REG != 0 && gi == 0);

            // Priority: squash > claim > release > spec-commit.
            always_comb begin
                b_n = busy_reg[gi];
                s_n = spec_reg[gi];
                t_n = tag_reg[gi];
                if (squash && spec_reg[gi]) begin
                    b_n = 1'b0;
                    s_n = 1'b0;
                    t_n = '0;
                end else if (claim_sel[gi]) begin
                    b_n = 1'b1;
                    s_n = di_spec & ~commit;
                    t_n = di_tag;
                end else if (rel_hit[gi]) begin
                    b_n = 1'b0;
                    s_n = 1'b0;
                end else if (commit) begin
                    s_n = 1'b0;
                end
            end

            assign busy_next[gi] = b_n;
            assign spec_next[gi] = s_n;
            assign tag_next[gi]  = t_n;
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
            logic             b;
            logic             s;
            logic [TAG_W-1:0] t;

            always_comb begin
                b = 1'b0;
                s = 1'b0;
                t = '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (rd_idx[gi*IDX_W +: IDX_W] == IDX_W'(r)) begin
                        b = busy_reg[r];
                        s = spec_reg[r];
                        t = tag_reg[r];
                    end
                end
            end

            assign rd_busy[gi]               = b;
            assign rd_spec[gi]               = s;
            assign rd_tag[gi*TAG_W +: TAG_W] = t;
        end
    endgenerate

    always_comb begin
        cnt_next = '0;
        for (int r = 0; r < NUM_REGS; r++)
            cnt_next = cnt_next + CNT_W'(busy_next[r]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_reg <= '0;
            spec_reg <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                tag_reg[r] <= '0;
            busy_cnt <= '0;
            err_waw  <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            spec_reg <= spec_next;
            for (int r = 0; r < NUM_REGS; r++)
                tag_reg[r] <= tag_next[r];
            busy_cnt <= cnt_next;
            err_waw  <= err_next;
        end
    end

endmodule

// File: tb/tb_rst_status_table.sv
// Scoreboard bench for rst_status_table: expectations queued with stimulus,
// popped and compared after the clock edge that should produce them.
`timescale 1ns/1ps
module tb_rst_status_table;

    localparam int IW = 5;
    localparam int TW = 2;

    localparam int K_BUSY = 0;
    localparam int K_TAG  = 1;
    localparam int K_SPEC = 2;
    localparam int K_CNT  = 3;
    localparam int K_ERR  = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          di_en;
    logic [IW-1:0] di_rd;
    logic [TW-1:0] di_tag;
    logic          di_spec;
    logic          di_waw;
    logic [3*IW-1:0] rd_idx;
    logic [2:0]      rd_busy;
    logic [3*TW-1:0] rd_tag;
    logic [2:0]      rd_spec;
    logic [1:0]      wb_en;
    logic [2*IW-1:0] wb_rd;
    logic [2*TW-1:0] wb_tag;
    logic          br_resolve;
    logic          br_mispredict;
    logic [5:0]    busy_cnt;
    logic          err_waw;

    rst_status_table dut (
        .CLK(CLK), .nRST(nRST),
        .di_en(di_en), .di_rd(di_rd), .di_tag(di_tag), .di_spec(di_spec), .di_waw(di_waw),
        .rd_idx(rd_idx), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_spec(rd_spec),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_tag(wb_tag),
        .br_resolve(br_resolve), .br_mispredict(br_mispredict),
        .busy_cnt(busy_cnt), .err_waw(err_waw)
    );

    always #50 CLK = ~CLK;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lp       = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic sb_push(input string name, input int kind, input int idx, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [IW-1:0] ix;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ix = e.idx[IW-1:0];
            rd_idx = {3{ix}};
            #1;
            case (e.kind)
                K_BUSY:  check(e.name, {31'd0, rd_busy[lp]}, e.exp);
                K_SPEC:  check(e.name, {31'd0, rd_spec[lp]}, e.exp);
                K_TAG:   check(e.name, {30'd0, rd_tag[lp*TW +: TW]}, e.exp);
                K_CNT:   check(e.name, {26'd0, busy_cnt}, e.exp);
                default: check(e.name, {31'd0, err_waw}, e.exp);
            endcase
            $display("check %s port %0d", e.name, lp);
            lp = (lp + 1) % 3;
        end
    endtask

    task automatic idle();
        di_en = 1'b0; di_rd = '0; di_tag = '0; di_spec = 1'b0;
        wb_en = '0; wb_rd = '0; wb_tag = '0;
        br_resolve = 1'b0; br_mispredict = 1'b0;
    endtask

    task automatic claim(input int rd, input int tag, input bit spec);
        di_en = 1'b1; di_rd = IW'(rd); di_tag = TW'(tag); di_spec = spec;
    endtask

    task automatic wb(input int p, input int rd, input int tag);
        wb_en[p] = 1'b1;
        wb_rd[p*IW +: IW]  = IW'(rd);
        wb_tag[p*TW +: TW] = TW'(tag);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        idle();
        drain();
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        rd_idx = '0;
        repeat (2) @(posedge CLK);
        #20 nRST = 1'b1;

        rd_idx = {5'd31, 5'd0, 5'd5};
        #1;
        check("rst_rd_busy", {29'd0, rd_busy}, 32'd0);
        check("rst_cnt", {26'd0, busy_cnt}, 32'd0);
        check("rst_err", {31'd0, err_waw}, 32'd0);

        claim(5, 2, 0);
        sb_push("c5_busy", K_BUSY, 5, 1); sb_push("c5_tag", K_TAG, 5, 2);
        sb_push("c5_spec", K_SPEC, 5, 0); sb_push("c5_cnt", K_CNT, 0, 1);
        step();

        wb(0, 5, 1);
        sb_push("stale_busy", K_BUSY, 5, 1); sb_push("stale_cnt", K_CNT, 0, 1);
        step();

        wb(1, 5, 2);
        sb_push("rel5_busy", K_BUSY, 5, 0); sb_push("rel5_cnt", K_CNT, 0, 0);
        step();

        claim(7, 1, 0);
        sb_push("c7_busy", K_BUSY, 7, 1); sb_push("c7_tag", K_TAG, 7, 1);
        step();

        claim(7, 3, 0);
        #1 check("waw7", {31'd0, di_waw}, 32'd1);
        sb_push("waw7_tag", K_TAG, 7, 1); sb_push("waw7_err", K_ERR, 0, 1);
        sb_push("waw7_cnt", K_CNT, 0, 1);
        step();

        sb_push("err_pulse_end", K_ERR, 0, 0);
        step();

        claim(7, 3, 0);
        wb(1, 7, 1);
        #1 check("waw7_rel", {31'd0, di_waw}, 32'd0);
        sb_push("own7_busy", K_BUSY, 7, 1); sb_push("own7_tag", K_TAG, 7, 3);
        sb_push("own7_err", K_ERR, 0, 0);
        step();

        wb(0, 7, 3);
        sb_push("rel7_cnt", K_CNT, 0, 0);
        step();

        claim(3, 1, 1); step();
        claim(4, 2, 0); step();
        claim(9, 0, 1);
        sb_push("pre_sq_cnt", K_CNT, 0, 3); sb_push("pre_sq_spec9", K_SPEC, 9, 1);
        step();

        br_resolve = 1'b1; br_mispredict = 1'b1;
        claim(10, 1, 1);
        sb_push("sq_b3", K_BUSY, 3, 0); sb_push("sq_b4", K_BUSY, 4, 1);
        sb_push("sq_b9", K_BUSY, 9, 0); sb_push("sq_b10", K_BUSY, 10, 0);
        sb_push("sq_t3", K_TAG, 3, 0); sb_push("sq_cnt", K_CNT, 0, 1);
        sb_push("sq_err", K_ERR, 0, 0);
        step();

        claim(3, 2, 1);
        sb_push("c3_spec", K_SPEC, 3, 1);
        step();

        br_resolve = 1'b1;
        claim(6, 1, 1);
        sb_push("cm_s3", K_SPEC, 3, 0); sb_push("cm_s6", K_SPEC, 6, 0);
        sb_push("cm_b3", K_BUSY, 3, 1); sb_push("cm_b6", K_BUSY, 6, 1);
        sb_push("cm_cnt", K_CNT, 0, 3);
        step();

        claim(11, 1, 1); step();
        br_resolve = 1'b1; br_mispredict = 1'b1;
        claim(12, 3, 0);
        sb_push("sq2_b11", K_BUSY, 11, 0); sb_push("sq2_b12", K_BUSY, 12, 1);
        sb_push("sq2_cnt", K_CNT, 0, 4);
        step();

        br_resolve = 1'b1; br_mispredict = 1'b1;
        claim(4, 1, 1);
        #1 check("sq_waw4", {31'd0, di_waw}, 32'd1);
        sb_push("sq_waw_err", K_ERR, 0, 0); sb_push("sq_waw_t4", K_TAG, 4, 2);
        step();

        wb(0, 12, 0);
        wb(1, 12, 3);
        sb_push("dual_b12", K_BUSY, 12, 0); sb_push("dual_cnt", K_CNT, 0, 3);
        step();

        claim(13, 1, 1); step();
        br_resolve = 1'b1; br_mispredict = 1'b1;
        wb(0, 13, 1);
        sb_push("sqrel_b13", K_BUSY, 13, 0); sb_push("sqrel_cnt", K_CNT, 0, 3);
        step();

        claim(0, 1, 0);
        #1 check("waw_r0", {31'd0, di_waw}, 32'd0);
        sb_push("r0_busy", K_BUSY, 0, 0); sb_push("r0_cnt", K_CNT, 0, 3);
        step();

        claim(20, 2, 0);
        sb_push("pre_rst_cnt", K_CNT, 0, 4);
        step();

        #20 nRST = 1'b0;
        sb_push("arst_b3", K_BUSY, 3, 0); sb_push("arst_b4", K_BUSY, 4, 0);
        sb_push("arst_b6", K_BUSY, 6, 0); sb_push("arst_b20", K_BUSY, 20, 0);
        sb_push("arst_cnt", K_CNT, 0, 0);
        drain();
        #10 nRST = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
